// File: rtl/gat_pkg.sv
// Shared GAT feature-path types: default word geometry, packed vector type
// and the feature-reader state encoding.
package gat_pkg;

  localparam int unsigned NEW_FEATURE_WIDTH = 32;
  localparam int unsigned NUM_FEATURE_OUT   = 16;

  typedef logic [NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] feat_vec_t;

  typedef enum logic [2:0] {
    RD_IDLE  = 3'd0,
    RD_FETCH = 3'd1,
    RD_WAIT  = 3'd2,
    RD_DRAIN = 3'd3,
    RD_DONE  = 3'd4
  } rd_state_e;

endpackage

// File: rtl/feat_rd_pipe.sv
// Delay line matching the BRAM read latency: carries each read's valid bit
// and lane index so they line up with the returning data word.
module feat_rd_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned LANE_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vld_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic              vld_o,
  output logic [LANE_W-1:0] lane_o
);

  logic [LATENCY-1:0]             vld_q, vld_d;
  logic [LATENCY-1:0][LANE_W-1:0] lane_q, lane_d;

  always_comb begin
    vld_d     = vld_q;
    lane_d    = lane_q;
    vld_d[0]  = vld_i;
    lane_d[0] = lane_i;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      lane_d[i] = lane_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      lane_q <= '0;
    end else begin
      vld_q  <= vld_d;
      lane_q <= lane_d;
    end
  end

  assign vld_o  = vld_q[LATENCY-1];
  assign lane_o = lane_q[LATENCY-1];

endmodule

// File: rtl/feature_reader.sv
// Drains the new-feature BRAM node by node, packing NUM_FEATURE_OUT words
// per node into one vector presented on a valid/ready stream.
module feature_reader #(
  parameter int unsigned NEW_FEATURE_WIDTH = gat_pkg::NEW_FEATURE_WIDTH,
  parameter int unsigned NUM_FEATURE_OUT   = gat_pkg::NUM_FEATURE_OUT,
  parameter int unsigned NUM_SUBGRAPHS     = 2708,
  parameter int unsigned READ_LATENCY      = 1,
  localparam int unsigned NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT,
  localparam int unsigned ADDR_W            = $clog2(NEW_FEATURE_DEPTH),
  localparam int unsigned NODE_W            = $clog2(NUM_SUBGRAPHS + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        start_i,
  input  logic [ADDR_W-1:0]                           base_addr_i,
  input  logic [NODE_W-1:0]                           num_nodes_i,
  output logic                                        busy_o,
  output logic                                        done_o,
  output logic [ADDR_W-1:0]                           feat_bram_addrb,
  output logic                                        feat_bram_enb,
  input  logic [NEW_FEATURE_WIDTH-1:0]                feat_bram_dout,
  output logic [NUM_FEATURE_OUT*NEW_FEATURE_WIDTH-1:0] feat_vec_o,
  output logic [NODE_W-1:0]                           feat_node_o,
  output logic                                        feat_vld_o,
  input  logic                                        feat_rdy_i
);

  import gat_pkg::*;

  localparam int unsigned LANE_W = (NUM_FEATURE_OUT > 1) ? $clog2(NUM_FEATURE_OUT) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_FEATURE_OUT - 1);

  typedef logic [NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] vec_t;

  rd_state_e         state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              enb_q, enb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [NODE_W-1:0] num_nodes_q, num_nodes_d;
  logic [NODE_W-1:0] fetch_cnt_q, fetch_cnt_d;
  logic [NODE_W-1:0] xfer_cnt_q, xfer_cnt_d;
  vec_t              shadow_q, shadow_d;
  logic              shadow_full_q, shadow_full_d;
  vec_t              out_vec_q, out_vec_d;
  logic [NODE_W-1:0] out_node_q, out_node_d;
  logic              vld_q, vld_d;

  logic              ret_vld;
  logic [LANE_W-1:0] ret_lane;
  logic              xfer;

  feat_rd_pipe #(
    .LATENCY (READ_LATENCY),
    .LANE_W  (LANE_W)
  ) u_rd_pipe (
    .clk    (clk),
    .rst    (rst),
    .vld_i  (enb_q),
    .lane_i (lane_q),
    .vld_o  (ret_vld),
    .lane_o (ret_lane)
  );

  // Shadow moves to the output whenever the output slot is free or draining.
  assign xfer = shadow_full_q && (!vld_q || feat_rdy_i);

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    enb_d         = enb_q;
    addr_d        = addr_q;
    lane_d        = lane_q;
    num_nodes_d   = num_nodes_q;
    fetch_cnt_d   = fetch_cnt_q;
    xfer_cnt_d    = xfer_cnt_q;
    shadow_d      = shadow_q;
    shadow_full_d = shadow_full_q;
    out_vec_d     = out_vec_q;
    out_node_d    = out_node_q;
    vld_d         = vld_q;

    if (ret_vld) begin
      shadow_d[ret_lane] = feat_bram_dout;
      if (ret_lane == LAST_LANE) shadow_full_d = 1'b1;
    end

    if (xfer) begin
      out_vec_d     = shadow_q;
      out_node_d    = xfer_cnt_q;
      xfer_cnt_d    = NODE_W'(xfer_cnt_q + 1'b1);
      vld_d         = 1'b1;
      shadow_full_d = 1'b0;
    end else if (vld_q && feat_rdy_i) begin
      vld_d = 1'b0;
    end

    case (state_q)
      RD_IDLE: begin
        if (start_i) begin
          busy_d     = 1'b1;
          xfer_cnt_d = '0;
          if (num_nodes_i == '0) begin
            state_d = RD_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = RD_FETCH;
            num_nodes_d = num_nodes_i;
            fetch_cnt_d = NODE_W'(1);
            enb_d       = 1'b1;
            addr_d      = base_addr_i;
            lane_d      = '0;
          end
        end
      end
      RD_FETCH: begin
        if (lane_q == LAST_LANE) begin
          enb_d   = 1'b0;
          state_d = RD_WAIT;
        end else begin
          lane_d = LANE_W'(lane_q + 1'b1);
          addr_d = ADDR_W'(addr_q + 1'b1);
        end
      end
      // Next fetch may only start once this node's shadow has moved out.
      RD_WAIT: begin
        if (xfer) begin
          if (fetch_cnt_q != num_nodes_q) begin
            state_d     = RD_FETCH;
            fetch_cnt_d = NODE_W'(fetch_cnt_q + 1'b1);
            enb_d       = 1'b1;
            addr_d      = ADDR_W'(addr_q + 1'b1);
            lane_d      = '0;
          end else begin
            state_d = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        if (vld_q && feat_rdy_i && !shadow_full_q) begin
          state_d = RD_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      RD_DONE: begin
        state_d = RD_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = RD_IDLE;
        busy_d  = 1'b0;
        enb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RD_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      enb_q         <= 1'b0;
      addr_q        <= '0;
      lane_q        <= '0;
      num_nodes_q   <= '0;
      fetch_cnt_q   <= '0;
      xfer_cnt_q    <= '0;
      shadow_q      <= '0;
      shadow_full_q <= 1'b0;
      out_vec_q     <= '0;
      out_node_q    <= '0;
      vld_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      enb_q         <= enb_d;
      addr_q        <= addr_d;
      lane_q        <= lane_d;
      num_nodes_q   <= num_nodes_d;
      fetch_cnt_q   <= fetch_cnt_d;
      xfer_cnt_q    <= xfer_cnt_d;
      shadow_q      <= shadow_d;
      shadow_full_q <= shadow_full_d;
      out_vec_q     <= out_vec_d;
      out_node_q    <= out_node_d;
      vld_q         <= vld_d;
    end
  end

  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign feat_bram_enb   = enb_q;
  assign feat_bram_addrb = addr_q;
  assign feat_vec_o      = out_vec_q;
  assign feat_node_o     = out_node_q;
  assign feat_vld_o      = vld_q;

endmodule

// File: tb/tb_feature_reader.sv
// Bench for feature_reader: two instances (read latency 1 and 2) fed from a
// behavioural BRAM; every vector is checked against words fetched from memory.
module tb_feature_reader;

  localparam int unsigned W      = 32;
  localparam int unsigned NF     = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned NODE_W = 12;
  localparam int unsigned VW     = W * NF;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              start_drv = 1'b0;
  logic              sel       = 1'b0;
  logic              rdy_drv   = 1'b0;
  logic [ADDR_W-1:0] base_drv  = '0;
  logic [NODE_W-1:0] nodes_drv = '0;

  logic              busy1, done1, enb1, vld1, busy2, done2, enb2, vld2;
  logic [ADDR_W-1:0] addr1, addr2;
  logic [W-1:0]      dout1, dout2;
  logic [VW-1:0]     vec1, vec2;
  logic [NODE_W-1:0] node1, node2;
  logic              start1, start2;

  assign start1 = start_drv & ~sel;
  assign start2 = start_drv & sel;

  feature_reader #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .base_addr_i(base_drv), .num_nodes_i(nodes_drv),
    .busy_o(busy1), .done_o(done1), .feat_bram_addrb(addr1), .feat_bram_enb(enb1),
    .feat_bram_dout(dout1), .feat_vec_o(vec1), .feat_node_o(node1), .feat_vld_o(vld1),
    .feat_rdy_i(rdy_drv)
  );

  feature_reader #(.READ_LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .base_addr_i(base_drv), .num_nodes_i(nodes_drv),
    .busy_o(busy2), .done_o(done2), .feat_bram_addrb(addr2), .feat_bram_enb(enb2),
    .feat_bram_dout(dout2), .feat_vec_o(vec2), .feat_node_o(node2), .feat_vld_o(vld2),
    .feat_rdy_i(rdy_drv)
  );

  // Behavioural BRAM: one- and two-cycle read ports over the same contents
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd1_q, rd2a_q, rd2b_q;
  always @(posedge clk) begin
    if (enb1) rd1_q <= mem[addr1];
    if (enb2) rd2a_q <= mem[addr2];
    rd2b_q <= rd2a_q;
  end
  assign dout1 = rd1_q;
  assign dout2 = rd2b_q;

  logic              busy_s, done_s, enb_s, vld_s;
  logic [ADDR_W-1:0] addr_s;
  logic [VW-1:0]     vec_s;
  logic [NODE_W-1:0] node_s;
  assign busy_s = sel ? busy2 : busy1;
  assign done_s = sel ? done2 : done1;
  assign enb_s  = sel ? enb2  : enb1;
  assign vld_s  = sel ? vld2  : vld1;
  assign addr_s = sel ? addr2 : addr1;
  assign vec_s  = sel ? vec2  : vec1;
  assign node_s = sel ? node2 : node1;

  int          cyc = 0;
  int          enb_cnt = 0;
  int unsigned addr_log[$];
  always @(posedge clk) begin
    cyc++;
    if (enb_s) begin
      enb_cnt++;
      addr_log.push_back(int'(addr_s));
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [W-1:0] salt);
    for (int k = 0; k < int'(DEPTH); k++) mem[k] = W'(k) ^ salt;
  endtask

  // Vector n of a command = NF consecutive memory words from base + n*NF
  function automatic logic [VW-1:0] exp_vec(input int unsigned base, input int unsigned n);
    logic [VW-1:0] v;
    v = '0;
    for (int f = 0; f < int'(NF); f++) v[f*W +: W] = mem[ADDR_W'(base + n*NF + f)];
    return v;
  endfunction

  // mode 0: rdy high; 1: random rdy; 2: 40-cycle stall after first vld
  task automatic run_cmd(input int unsigned base, input int unsigned nodes, input int mode,
                         input int exp_lat, input bit poke, input string tag);
    int got_n = 0;
    int lat = -1;
    int stall = 0;
    int budget = 400 + 80 * int'(nodes);
    int e0 = 0;
    int estart, astart, t0;
    int abad = 0;
    logic pv = 1'b0;
    logic pr = 1'b1;
    logic r;
    logic [VW-1:0] pvec = '0;
    logic [NODE_W-1:0] pnode = '0;
    estart = enb_cnt;
    astart = addr_log.size();
    @(negedge clk);
    start_drv = 1'b1;
    base_drv  = ADDR_W'(base);
    nodes_drv = NODE_W'(nodes);
    rdy_drv   = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    t0 = cyc;
    while (got_n < int'(nodes) && budget > 0) begin
      if (pv && !pr) begin
        chk({tag, "_hold_vld"}, VW'(vld_s), VW'(1'b1));
        chk({tag, "_hold_vec"}, vec_s, pvec);
        chk({tag, "_hold_node"}, VW'(node_s), VW'(pnode));
      end
      if (vld_s && lat < 0) begin
        lat = cyc - t0;
        e0  = enb_cnt;
        if (exp_lat > 0) chk({tag, "_first_vld"}, VW'(lat), VW'(exp_lat));
      end
      case (mode)
        1:       r = 1'($urandom_range(0, 1));
        2:       r = (lat < 0) || (stall >= 40);
        default: r = 1'b1;
      endcase
      if (mode == 2 && lat >= 0) begin
        if (stall == 40) begin
          chk({tag, "_stall_reads"}, VW'(enb_cnt - e0), VW'(NF));
          chk({tag, "_stall_enb"}, VW'(enb_s), VW'(1'b0));
        end
        stall++;
      end
      if (poke && (cyc - t0 == 5)) begin
        start_drv = 1'b1;
        base_drv  = ADDR_W'(base + 999);
        nodes_drv = NODE_W'(7);
      end else begin
        start_drv = 1'b0;
      end
      rdy_drv = r;
      if (vld_s && r) begin
        chk({tag, "_vec"}, vec_s, exp_vec(base, got_n));
        chk({tag, "_node"}, VW'(node_s), VW'(got_n));
        got_n++;
      end
      pv = vld_s; pr = r; pvec = vec_s; pnode = node_s;
      budget--;
      @(negedge clk);
    end
    chk({tag, "_count"}, VW'(got_n), VW'(nodes));
    chk({tag, "_done_busy"}, VW'({done_s, busy_s}), VW'(2'b10));
    @(negedge clk);
    chk({tag, "_idle"}, VW'({done_s, busy_s, vld_s}), VW'(3'b000));
    chk({tag, "_nreads"}, VW'(enb_cnt - estart), VW'(nodes * NF));
    for (int i = astart; i < addr_log.size(); i++)
      if (addr_log[i] != (base + unsigned'(i - astart)) % DEPTH) abad++;
    chk({tag, "_addr"}, VW'(abad), VW'(0));
  endtask

  initial begin
    int e;
    fill('0);
    repeat (3) @(negedge clk);
    chk("reset_ctl", VW'({vld1, busy1, done1, enb1, addr1, node1, vld2, busy2, done2, enb2, addr2, node2}), '0);
    chk("reset_vec", vec1 | vec2, '0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(0, 3, 0, 18, 1'b0, "basic");
    sel = 1'b1;
    run_cmd(0, 3, 0, 19, 1'b0, "rl2");
    sel = 1'b0;
    run_cmd(200, 3, 2, 18, 1'b0, "bp");

    // zero-node command
    e = enb_cnt;
    @(negedge clk);
    start_drv = 1'b1; base_drv = ADDR_W'(5); nodes_drv = '0;
    @(negedge clk);
    start_drv = 1'b0;
    chk("zero_done_busy", VW'({done_s, busy_s}), VW'(2'b11));
    @(negedge clk);
    chk("zero_end", VW'({done_s, busy_s}), VW'(2'b00));
    repeat (4) @(negedge clk);
    chk("zero_no_reads", VW'(enb_cnt - e), VW'(0));

    run_cmd(40, 2, 0, 18, 1'b1, "ignore");
    run_cmd(DEPTH - 4, 1, 0, 18, 1'b0, "wrap");

    // reset in the middle of node 1's fetch
    @(negedge clk);
    start_drv = 1'b1; base_drv = ADDR_W'(100); nodes_drv = NODE_W'(4); rdy_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (22) @(negedge clk);
    chk("midrst_fetching", VW'(enb_s), VW'(1'b1));
    rst = 1'b1;
    #1;
    chk("midrst_ctl", VW'({vld_s, busy_s, done_s, enb_s, addr_s, node_s}), '0);
    chk("midrst_vec", vec_s, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("midrst_quiet", VW'({done_s, busy_s, vld_s}), VW'(3'b000));
    end
    fill(W'($urandom));
    run_cmd($urandom_range(0, DEPTH - 1), 2, 0, 18, 1'b0, "post_rst");

    for (int k = 0; k < 4; k++)
      run_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 4), 1, 0, 1'b0, "rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
